// File: rtl/fp16_pkg.sv
// Shared FP16 field layout and arbiter state encoding used by the multiplier
// and its arbiter.
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int EXP_BIAS = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fmul16.sv
// Combinational half-precision multiplier: truncating, hidden bit always set,
// zero magnitude forces a signed zero, no inf/NaN/overflow handling.
module fmul16
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic                   sign;
  logic [MANT_W:0]        ma;
  logic [MANT_W:0]        mb;
  logic [2*MANT_W+1:0]    prod;
  logic                   norm;
  logic [EXP_W+1:0]       esum;
  logic [MANT_W-1:0]      mant;
  logic                   unused_bits;

  always_comb begin
    sign = a[SIGN_BIT] ^ b[SIGN_BIT];
    ma   = {1'b1, a[MANT_W-1:0]};
    mb   = {1'b1, b[MANT_W-1:0]};
    prod = ma * mb;
    norm = prod[2*MANT_W+1];
    // Only the low EXP_W bits are kept, so the exponent wraps modulo 32.
    esum = {2'b00, a[SIGN_BIT-1:MANT_W]} + {2'b00, b[SIGN_BIT-1:MANT_W]}
         + {{(EXP_W+1){1'b0}}, norm} - (EXP_W+2)'(EXP_BIAS);
    mant = norm ? prod[2*MANT_W:MANT_W+1] : prod[2*MANT_W-1:MANT_W];
    if (a[SIGN_BIT-1:0] == '0 || b[SIGN_BIT-1:0] == '0)
      y = {sign, 15'b0};
    else
      y = {sign, esum[EXP_W-1:0], mant};
  end

  // Truncated product bits and the exponent carry are intentionally dropped.
  assign unused_bits = ^{prod[MANT_W-1:0], esum[EXP_W+1:EXP_W]};

endmodule

// File: rtl/fmul16_arbiter.sv
// Round-robin arbiter sharing one fmul16 among NREQ requesters, with
// registered operands and a result held until the owner acknowledges it.
module fmul16_arbiter
  import fp16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_result,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr, owner, grant_idx, next_ptr;
  logic            grant_ok, handshake, ack;
  logic [15:0]     op_a, op_b, result_q, mul_y, ops_q;

  // Scanning from the farthest offset down leaves the closest valid one at rr_ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] pick;
    int           j;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (valid[j]) pick = {1'b1, IDW'(j)};
    end
    return pick;
  endfunction

  always_comb {grant_ok, grant_idx} = rr_pick(req_valid, rr_ptr);

  assign handshake = (state_q == IDLE) && !reset && grant_ok;
  assign ack       = (state_q == RESP) && rsp_ready[owner];
  assign next_ptr  = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

  fmul16 u_mul (
    .a (op_a),
    .b (op_b),
    .y (mul_y)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet during the reset cycle itself, not only after it.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      if (state_q == IDLE && grant_ok) req_ready[grant_idx] = 1'b1;
      if (state_q == RESP)             rsp_valid[owner]     = 1'b1;
    end
  end

  assign rsp_result = reset ? '0 : result_q;
  assign ops_done   = reset ? '0 : ops_q;

  // NOTE: datapath registers are reset too, so an aborted op leaves no stale result visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      ops_q    <= '0;
    end else begin
      if (handshake) begin
        owner <= grant_idx;
        op_a  <= req_a[16*grant_idx +: 16];
        op_b  <= req_b[16*grant_idx +: 16];
      end
      if (state_q == MUL) result_q <= mul_y;
      if (ack) begin
        rr_ptr <= next_ptr;
        ops_q  <= ops_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/fmul16_arbiter.md
# fmul16_arbiter

Shares a single combinational half-precision multiplier (`fmul16`) among `NREQ` requesters, such as the multi-cycle core's FP execute state and a vector/DMA helper. Requests are granted round-robin through a valid/ready handshake, and the granted operands are registered. The product is registered and held on a shared result bus until the owning requester acknowledges it. The block sits between the requesters' control FSMs and the multiplier datapath, and is the only instantiation point of `fmul16`.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters. Legal range 2..4.
- `IDW`, default `$clog2(NREQ)`: owner-index width. Derived; do not override.

Ports:
- `clk`  in  1  system clock. Every flop is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_a`  in  16*NREQ  operand A. Requester i uses `[16*i+15:16*i]`.
- `req_b`  in  16*NREQ  operand B, same packing as `req_a`.
- `req_ready`  out  NREQ  grant/accept. One-hot or zero.
- `rsp_valid`  out  NREQ  result valid for the owner. One-hot or zero.
- `rsp_result`  out  16  product, shared bus.
- `rsp_ready`  in  NREQ  result acknowledge.
- `busy`  out  1  high whenever the state is not IDLE.
- `ops_done`  out  16  count of completed multiplies. Wraps at 0xFFFF→0.

## Operation
- FSM has three states: IDLE, MUL, RESP.
- **IDLE:**
  - Grant the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap.
  - Drive `req_ready[grant]=1` combinationally. Only in IDLE, and only when not in reset.
  - On handshake (`req_valid[g] & req_ready[g]`): capture `op_a`/`op_b` from slice g, set `owner<=g`, go to MUL.
  - With no valid request, stay in IDLE.
- **MUL:** `result_q <= fmul16(op_a, op_b)`. Go to RESP unconditionally.
- **RESP:**
  - `rsp_valid[owner]=1`; `rsp_result=result_q`.
  - When `rsp_ready[owner]=1`: go to IDLE, set `rr_ptr <= owner+1` (mod NREQ), increment `ops_done`.
  - `rsp_ready` from non-owners is ignored.
- **Multiplier semantics (fixed):**
  - Result sign = `a[15]^b[15]`.
  - If either magnitude `[14:0]` is zero, the result is `{sign,15'b0}`.
  - Otherwise: 5-bit exponent = `ea+eb-15` mod 32, 11×11 mantissa product, normalize by one bit when product bit 21 is set, truncate with no rounding.
  - No inf/NaN/overflow handling.
- `req_a`/`req_b` may change after acceptance; the registered copies are used.
- Reset mid-operation aborts the operation silently. No `rsp_valid` is ever produced for it.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: MUL.
- Cycle 2: earliest `rsp_valid`. Load-to-response latency is 2 cycles.
- Minimum issue interval is 3 cycles (ack in cycle 2, next grant in cycle 3).
- An ack cycle never grants: `req_ready` is low in RESP even if requests are pending.
- A requester that holds `req_valid` after being served yields to any other pending requester. With only one requester active, it is re-granted every 3 cycles.
- `rsp_valid` and `rsp_result` stay stable until ack, for unbounded back-pressure.
- Reset values (including the cycle `reset` is high):
  - `state=IDLE`, `rr_ptr=0`, `owner=0`.
  - `op_a=op_b=result_q=0`.
  - `ops_done=0`.
  - `req_ready=0`, `rsp_valid=0`, `rsp_result=0`, `busy=0`.

## Structure
- Shared package `fp16_pkg` holds:
  - FP16 field constants: `SIGN_BIT=15`, `EXP_W=5`, `MANT_W=10`, `EXP_BIAS=15`.
  - State enum: IDLE=2'd0, MUL=2'd1, RESP=2'd2.
- One sub-module: `fmul16` instance `u_mul`, purely combinational. No other hierarchy.
- Round-robin priority is a local function or always-block, not a separate module.

## Test plan
- **Single op:** requester 0 sends a=0x4000, b=0x4200.
  - `req_ready[0]` is high in cycle 0.
  - `rsp_valid[0]` and `rsp_result=0x4600` appear in cycle 2.
  - Ack in cycle 2 → `ops_done=1`, `busy=0` in cycle 3.
- **Normalization:** a=b=0x3E00 (1.5) → 0x4080 (2.25).
- **Signed zero:** a=0xC000, b=0x0000 → 0x8000.
- **Contention:** both requesters hold valid from reset.
  - Grants go 0, 1, 0, 1 in cycles 0, 3, 6, 9.
  - `rsp_valid` is always one-hot and matches the owner.
- **Back-pressure:** hold `rsp_ready[owner]=0` for 10 cycles.
  - `rsp_result` stays stable.
  - `req_ready` stays 0 throughout, despite the other requester's valid.
  - A foreign `rsp_ready` pulse does not release.
- **Reset mid-op:** assert `reset` during MUL.
  - All outputs read 0 next cycle.
  - No `rsp_valid` appears for the aborted op.
  - `ops_done=0`; the next grant starts at requester 0.
